// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control for a 5-stage MIPS pipe: main/ALU decode, ID/EX control register,
// load-use stall and jump/branch flush. Define PIPE_CTRL_STATS_EN to add stall/flush counters.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [5:0]            id_funct,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  id_jump,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_branch_eq,
    output logic                  ex_branch_ne,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [1:0]            ctrl_state
`ifdef PIPE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    generate
        if (ALU_CTRL_W < 4 || CNT_W < 1) begin : g_bad_cfg
            $error("pipe_ctrl_unit: ALU_CTRL_W must be >= 4 and CNT_W >= 1");
        end
    endgenerate

    state_t     state, state_nx;
    logic       d_reg_write, d_mem_read, d_mem_to_reg, d_mem_write, d_alu_src;
    logic       d_beq, d_bne, d_jump, d_use_rd, d_live;
    logic [3:0] d_alu;
    logic       rt_used, ld_use, br_flush, load_ex;

    // d_live marks an instruction that produces a non-bubble ID/EX bundle
    always_comb begin
        d_reg_write  = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_to_reg = 1'b0;
        d_mem_write  = 1'b0;
        d_alu_src    = 1'b0;
        d_beq        = 1'b0;
        d_bne        = 1'b0;
        d_jump       = 1'b0;
        d_use_rd     = 1'b0;
        d_live       = 1'b0;
        d_alu        = 4'b0000;
        if (id_valid) begin
            case (id_opcode)
                OP_RTYPE: begin
                    d_use_rd = 1'b1;
                    d_live   = 1'b1;
                    case (id_funct)
                        6'b100000: d_alu = 4'b0010;
                        6'b100010: d_alu = 4'b0110;
                        6'b100100: d_alu = 4'b0000;
                        6'b100101: d_alu = 4'b0001;
                        6'b101010: d_alu = 4'b0111;
                        default:   d_live = 1'b0;
                    endcase
                    d_reg_write = d_live;
                end
                OP_ADDI: begin
                    d_live = 1'b1; d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu = 4'b0010;
                end
                OP_ANDI: begin
                    d_live = 1'b1; d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu = 4'b0000;
                end
                OP_LW: begin
                    d_live = 1'b1; d_reg_write = 1'b1; d_mem_read = 1'b1;
                    d_mem_to_reg = 1'b1; d_alu_src = 1'b1; d_alu = 4'b0010;
                end
                OP_SW: begin
                    d_live = 1'b1; d_mem_write = 1'b1; d_alu_src = 1'b1; d_alu = 4'b0010;
                end
                OP_BEQ: begin
                    d_live = 1'b1; d_beq = 1'b1; d_alu = 4'b0110;
                end
                OP_BNE: begin
                    d_live = 1'b1; d_bne = 1'b1; d_alu = 4'b0110;
                end
                OP_J:    d_jump = 1'b1;
                default: ;
            endcase
        end
    end

    assign rt_used  = (id_opcode == OP_RTYPE) || (id_opcode == OP_BEQ) ||
                      (id_opcode == OP_BNE)   || (id_opcode == OP_SW);
    assign ld_use   = id_valid && ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (rt_used && (ex_rt == id_rt)));
    assign br_flush = ex_branch_taken && (ex_branch_eq || ex_branch_ne);

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    // A stall ends by itself: the bubble it inserts clears ex_mem_read
    always_comb begin
        state_nx = RUN;
        if (br_flush)    state_nx = FLUSH;
        else if (ld_use) state_nx = STALL;
        else if (d_jump) state_nx = FLUSH;
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        id_jump    = 1'b0;
        load_ex    = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end else begin
            case (state_nx)
                FLUSH: begin
                    ifid_flush = 1'b1;
                    id_jump    = !br_flush;
                end
                STALL: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
                default: load_ex = 1'b1;
            endcase
        end
    end

    assign ctrl_state = state;

    always_ff @(posedge clk) begin
        if (reset || !load_ex) begin
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_branch_eq  <= 1'b0;
            ex_branch_ne  <= 1'b0;
            ex_alu_ctrl   <= '0;
            ex_dest       <= '0;
            ex_rt         <= '0;
        end else begin
            ex_reg_write  <= d_reg_write;
            ex_mem_read   <= d_mem_read;
            ex_mem_to_reg <= d_mem_to_reg;
            ex_mem_write  <= d_mem_write;
            ex_alu_src    <= d_alu_src;
            ex_branch_eq  <= d_beq;
            ex_branch_ne  <= d_bne;
            ex_alu_ctrl   <= ALU_CTRL_W'(d_alu);
            ex_dest       <= d_live ? (d_use_rd ? id_rd : id_rt) : '0;
            ex_rt         <= d_live ? id_rt : '0;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    // Counters saturate at all-ones; a j counts as a flush cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state_nx == STALL && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (state_nx == FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
